reorder_buffer: RTL and testbench

In-order retirement queue between Rename and the functional units. Every renamed instruction enters in program order and records its new physical destination and the tag it displaced. An entry completes when its tag is broadcast on the FU wakeup bus. Up to two completed instructions retire per cycle from the head, and each retirement returns the displaced tag to Rename's free pool on `freed_tag_1`/`freed_tag_2`.

---
 rtl/reorder_buffer_if.sv | 42 ++++
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 tb/tb_reorder_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, wakeup and retire signals between Rename/FUs (master) and the reorder buffer (slave).
interface rob_if #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 6
);
  localparam int IDX_W = $clog2(ROB_SIZE);

  logic             dispatch_valid;
  logic [TAG_W-1:0] dispatch_physical_rd;
  logic [TAG_W-1:0] dispatch_old_physical_rd;
  logic             dispatch_complete;
  logic [IDX_W-1:0] dispatch_rob_index;

  logic             wakeup_0_active;
  logic [TAG_W-1:0] wakeup_0_tag;
  logic             wakeup_1_active;
  logic [TAG_W-1:0] wakeup_1_tag;
  logic             wakeup_2_active;
  logic [TAG_W-1:0] wakeup_2_tag;
  logic             wakeup_3_active;
  logic [TAG_W-1:0] wakeup_3_tag;

  logic [TAG_W-1:0] freed_tag_1;
  logic [TAG_W-1:0] freed_tag_2;
  logic [1:0]       retire_count;
  logic             rob_full;
  logic             rob_empty;

  modport master (
    output dispatch_valid, dispatch_physical_rd, dispatch_old_physical_rd, dispatch_complete,
    output wakeup_0_active, wakeup_0_tag, wakeup_1_active, wakeup_1_tag,
    output wakeup_2_active, wakeup_2_tag, wakeup_3_active, wakeup_3_tag,
    input  dispatch_rob_index, freed_tag_1, freed_tag_2, retire_count, rob_full, rob_empty
  );

  modport slave (
    input  dispatch_valid, dispatch_physical_rd, dispatch_old_physical_rd, dispatch_complete,
    input  wakeup_0_active, wakeup_0_tag, wakeup_1_active, wakeup_1_tag,
    input  wakeup_2_active, wakeup_2_tag, wakeup_3_active, wakeup_3_tag,
    output dispatch_rob_index, freed_tag_1, freed_tag_2, retire_count, rob_full, rob_empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: one dispatch and up to two retires per cycle, freeing displaced tags.
// Optional simulation invariant checks are compiled when ROB_INVARIANT_CHECKS_EN is defined.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 6
) (
  input  logic clk,
  input  logic reset_n,
  rob_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_complete;
  logic [TAG_W-1:0]    r_prd [ROB_SIZE];
  logic [TAG_W-1:0]    r_old [ROB_SIZE];
  logic [IDX_W-1:0]    r_head;
  logic [IDX_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [TAG_W-1:0]    r_freed_1;
  logic [TAG_W-1:0]    r_freed_2;
  logic [1:0]          r_retire_count;

  logic [3:0]          w_wk_act;
  logic [TAG_W-1:0]    w_wk_tag [4];
  logic [ROB_SIZE-1:0] w_wake_hit;
  logic [ROB_SIZE-1:0] w_valid_next;
  logic [ROB_SIZE-1:0] w_complete_next;
  logic [3:0]          w_disp_lane_hit;
  logic                w_disp_complete;
  logic                w_full;
  logic                w_dispatch;
  logic [IDX_W-1:0]    w_head_p1;
  logic                w_r0;
  logic                w_r1;
  logic [1:0]          w_ret_n;

  assign w_wk_act    = {bus.wakeup_3_active, bus.wakeup_2_active,
                        bus.wakeup_1_active, bus.wakeup_0_active};
  assign w_wk_tag[0] = bus.wakeup_0_tag;
  assign w_wk_tag[1] = bus.wakeup_1_tag;
  assign w_wk_tag[2] = bus.wakeup_2_tag;
  assign w_wk_tag[3] = bus.wakeup_3_tag;

  assign w_full     = (r_count == CNT_W'(ROB_SIZE));
  assign w_dispatch = bus.dispatch_valid && !w_full;

  // Retire decisions use only registered complete bits, so same-edge wakeups wait one cycle.
  assign w_head_p1 = r_head + 1'b1;
  assign w_r0      = r_valid[r_head] && r_complete[r_head];
  assign w_r1      = w_r0 && r_valid[w_head_p1] && r_complete[w_head_p1];
  assign w_ret_n   = {1'b0, w_r0} + {1'b0, w_r1};

  genvar gi, gj;
  generate
    for (gj = 0; gj < 4; gj++) begin : g_disp_lane
      assign w_disp_lane_hit[gj] = w_wk_act[gj] && (w_wk_tag[gj] == bus.dispatch_physical_rd);
    end
  endgenerate

  assign w_disp_complete = bus.dispatch_complete ||
                           ((bus.dispatch_physical_rd != '0) && (|w_disp_lane_hit));

  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
      localparam logic [IDX_W-1:0] L_IDX = IDX_W'(gi);
      logic [3:0] w_lane_hit;
      logic       w_clr;
      logic       w_set;

      for (gj = 0; gj < 4; gj++) begin : g_lane
        assign w_lane_hit[gj] = w_wk_act[gj] && (w_wk_tag[gj] == r_prd[gi]);
      end

      assign w_wake_hit[gi] = (r_prd[gi] != '0) && (|w_lane_hit);
      assign w_clr = (w_r0 && (r_head == L_IDX)) || (w_r1 && (w_head_p1 == L_IDX));
      assign w_set = w_dispatch && (r_tail == L_IDX);

      assign w_valid_next[gi]    = w_clr ? 1'b0 : (w_set ? 1'b1 : r_valid[gi]);
      assign w_complete_next[gi] = w_clr ? 1'b0 :
                                   (w_set ? w_disp_complete
                                          : (r_complete[gi] || (r_valid[gi] && w_wake_hit[gi])));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= '0;
      r_complete     <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_freed_1      <= '0;
      r_freed_2      <= '0;
      r_retire_count <= '0;
    end else begin
      r_valid        <= w_valid_next;
      r_complete     <= w_complete_next;
      r_head         <= r_head + IDX_W'(w_ret_n);
      r_tail         <= r_tail + IDX_W'(w_dispatch);
      r_count        <= r_count + CNT_W'(w_dispatch) - CNT_W'(w_ret_n);
      r_freed_1      <= w_r0 ? r_old[r_head] : '0;
      r_freed_2      <= w_r1 ? r_old[w_head_p1] : '0;
      r_retire_count <= w_ret_n;
    end
  end

  // Tag payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_dispatch) begin
      r_prd[r_tail] <= bus.dispatch_physical_rd;
      r_old[r_tail] <= bus.dispatch_old_physical_rd;
    end
  end

  assign bus.dispatch_rob_index = r_tail;
  assign bus.freed_tag_1        = r_freed_1;
  assign bus.freed_tag_2        = r_freed_2;
  assign bus.retire_count       = r_retire_count;
  assign bus.rob_full           = w_full;
  assign bus.rob_empty          = (r_count == '0);

`ifdef ROB_INVARIANT_CHECKS_EN
  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.dispatch_valid && w_full)
        $fatal(1, "reorder_buffer: dispatch while full");
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (w_wk_act[i] && w_wk_act[j] && (w_wk_tag[i] == w_wk_tag[j]))
            $fatal(1, "reorder_buffer: duplicate wakeup tag %0d", w_wk_tag[i]);
      for (int k = 0; k < ROB_SIZE; k++) begin
        if (r_valid[k] && r_complete[k] && w_wake_hit[k])
          $fatal(1, "reorder_buffer: wakeup of completed entry %0d", k);
        if (w_dispatch && (bus.dispatch_physical_rd != '0) && r_valid[k] &&
            (r_prd[k] == bus.dispatch_physical_rd))
          $fatal(1, "reorder_buffer: dispatch tag %0d already in flight", bus.dispatch_physical_rd);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: cycle vectors plus a freed-tag scoreboard and corner sequences.
module tb_reorder_buffer;
  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = 6;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rob_if #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) bus ();

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic       dv;
    logic [5:0] rd;
    logic [5:0] old;
    logic       dc;
    int         wlane;
    logic [5:0] wtag;
    int         rc;
    int         f1;
    int         f2;
    int         full;
    int         empty;
    int         idx;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [TAG_W-1:0] exp_q[$];
  vec_t vecs[16];

  function automatic vec_t mk(input logic dv, input int rd, input int old, input logic dc,
                              input int wlane, input int wtag, input int rc, input int f1,
                              input int f2, input int full, input int empty, input int idx);
    vec_t v;
    v.dv = dv; v.rd = 6'(rd); v.old = 6'(old); v.dc = dc;
    v.wlane = wlane; v.wtag = 6'(wtag);
    v.rc = rc; v.f1 = f1; v.f2 = f2; v.full = full; v.empty = empty; v.idx = idx;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_physical_rd = '0;
    bus.dispatch_old_physical_rd = '0;
    bus.dispatch_complete = 1'b0;
    bus.wakeup_0_active = 1'b0; bus.wakeup_0_tag = '0;
    bus.wakeup_1_active = 1'b0; bus.wakeup_1_tag = '0;
    bus.wakeup_2_active = 1'b0; bus.wakeup_2_tag = '0;
    bus.wakeup_3_active = 1'b0; bus.wakeup_3_tag = '0;
  endtask

  task automatic set_wake(input int lane, input logic [TAG_W-1:0] tag);
    case (lane)
      0: begin bus.wakeup_0_active = 1'b1; bus.wakeup_0_tag = tag; end
      1: begin bus.wakeup_1_active = 1'b1; bus.wakeup_1_tag = tag; end
      2: begin bus.wakeup_2_active = 1'b1; bus.wakeup_2_tag = tag; end
      3: begin bus.wakeup_3_active = 1'b1; bus.wakeup_3_tag = tag; end
      default: ;
    endcase
  endtask

  task automatic disp(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] old, input logic c);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_physical_rd = rd;
    bus.dispatch_old_physical_rd = old;
    bus.dispatch_complete = c;
    exp_q.push_back(old);
  endtask

  // Each retire pops the oldest dispatched old tag; idle slots must read zero.
  task automatic monitor();
    logic [TAG_W-1:0] e;
    chk("retire_count_range", int'(bus.retire_count <= 2'd2), 1);
    if (bus.retire_count != 2'd0)
      $display("retire n=%0d freed_1=%0d freed_2=%0d", bus.retire_count, bus.freed_tag_1, bus.freed_tag_2);
    if (bus.retire_count >= 2'd1) begin
      if (exp_q.size() == 0) chk("sb_underflow_1", 0, 1);
      else begin e = exp_q.pop_front(); chk("sb_freed_1", int'(bus.freed_tag_1), int'(e)); end
    end else chk("idle_freed_1", int'(bus.freed_tag_1), 0);
    if (bus.retire_count == 2'd2) begin
      if (exp_q.size() == 0) chk("sb_underflow_2", 0, 1);
      else begin e = exp_q.pop_front(); chk("sb_freed_2", int'(bus.freed_tag_2), int'(e)); end
    end else chk("idle_freed_2", int'(bus.freed_tag_2), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic chk_outs(input string tag, input int rc, input int f1, input int f2,
                          input int full, input int empty, input int idx);
    chk({tag, "_retire_count"}, int'(bus.retire_count), rc);
    chk({tag, "_freed_1"}, int'(bus.freed_tag_1), f1);
    chk({tag, "_freed_2"}, int'(bus.freed_tag_2), f2);
    chk({tag, "_full"}, int'(bus.rob_full), full);
    chk({tag, "_empty"}, int'(bus.rob_empty), empty);
    chk({tag, "_index"}, int'(bus.dispatch_rob_index), idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // dv rd old dc | wake lane/tag | rc f1 f2 full empty idx (outputs after the edge)
    vecs[0]  = mk(1, 32, 5, 0, -1,  0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(0,  0, 0, 0,  0, 32, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0,  0, 0, 0, -1,  0, 1, 5, 0, 0, 1, 1);
    vecs[3]  = mk(0,  0, 0, 0, -1,  0, 0, 0, 0, 0, 1, 1);
    vecs[4]  = mk(1, 33, 7, 0, -1,  0, 0, 0, 0, 0, 0, 2);
    vecs[5]  = mk(1, 34, 8, 0, -1,  0, 0, 0, 0, 0, 0, 3);
    vecs[6]  = mk(0,  0, 0, 0,  2, 34, 0, 0, 0, 0, 0, 3);
    vecs[7]  = mk(0,  0, 0, 0, -1,  0, 0, 0, 0, 0, 0, 3);
    vecs[8]  = mk(0,  0, 0, 0,  3, 33, 0, 0, 0, 0, 0, 3);
    vecs[9]  = mk(0,  0, 0, 0, -1,  0, 2, 7, 8, 0, 1, 3);
    vecs[10] = mk(0,  0, 0, 0, -1,  0, 0, 0, 0, 0, 1, 3);
    vecs[11] = mk(1, 40, 0, 0,  1, 40, 0, 0, 0, 0, 0, 4);
    vecs[12] = mk(0,  0, 0, 0, -1,  0, 1, 0, 0, 0, 1, 4);
    vecs[13] = mk(1,  0, 9, 1, -1,  0, 0, 0, 0, 0, 0, 5);
    vecs[14] = mk(1,  0,10, 1, -1,  0, 1, 9, 0, 0, 0, 6);
    vecs[15] = mk(0,  0, 0, 0, -1,  0, 1,10, 0, 0, 1, 6);

    clear_in();
    #1 reset_n = 1'b0;
    #2;
    chk_outs("reset", 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      clear_in();
      if (vecs[i].dv) disp(vecs[i].rd, vecs[i].old, vecs[i].dc);
      if (vecs[i].wlane >= 0) set_wake(vecs[i].wlane, vecs[i].wtag);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].rc, vecs[i].f1, vecs[i].f2,
               vecs[i].full, vecs[i].empty, vecs[i].idx);
    end

    // Fill all 16 entries from index 6, then try a 17th dispatch.
    for (int i = 0; i < 16; i++) begin
      clear_in();
      disp(6'(10 + i), 6'(40 + i), 1'b0);
      step();
    end
    chk("full_flag", int'(bus.rob_full), 1);
    chk("full_not_empty", int'(bus.rob_empty), 0);
    chk("full_index", int'(bus.dispatch_rob_index), 6);
    clear_in();
    bus.dispatch_valid = 1'b1;
    bus.dispatch_physical_rd = 6'd30;
    bus.dispatch_old_physical_rd = 6'd63;
    step();
    chk("drop_index", int'(bus.dispatch_rob_index), 6);
    chk("drop_full", int'(bus.rob_full), 1);
    for (int c = 0; c < 4; c++) begin
      clear_in();
      for (int l = 0; l < 4; l++) set_wake(l, 6'(10 + 4 * c + l));
      step();
    end
    clear_in();
    for (int k = 0; k < 20 && !bus.rob_empty; k++) step();
    chk("drain_empty", int'(bus.rob_empty), 1);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_index", int'(bus.dispatch_rob_index), 6);

    // Advance to index 15 with self-completing entries, then straddle the wrap.
    for (int i = 0; i < 9; i++) begin
      clear_in();
      disp(6'd0, 6'(1 + i), 1'b1);
      step();
    end
    clear_in();
    step();
    step();
    chk("prewrap_index", int'(bus.dispatch_rob_index), 15);
    chk("prewrap_empty", int'(bus.rob_empty), 1);
    disp(6'd50, 6'd21, 1'b0);
    step();
    chk("wrap_index_0", int'(bus.dispatch_rob_index), 0);
    clear_in();
    disp(6'd51, 6'd22, 1'b0);
    step();
    chk("wrap_index_1", int'(bus.dispatch_rob_index), 1);
    clear_in();
    set_wake(0, 6'd51);
    set_wake(1, 6'd50);
    step();
    chk("wrap_wake_rc", int'(bus.retire_count), 0);
    clear_in();
    step();
    chk_outs("wrap_retire", 2, 21, 22, 0, 1, 1);

    // Asynchronous reset with five entries pending.
    for (int i = 0; i < 5; i++) begin
      clear_in();
      disp(6'(56 + i), 6'(31 + i), 1'b0);
      step();
    end
    clear_in();
    chk("prereset_empty", int'(bus.rob_empty), 0);
    #2 reset_n = 1'b0;
    #1;
    chk_outs("midreset", 0, 0, 0, 0, 1, 0);
    exp_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int l = 0; l < 4; l++) set_wake(l, 6'(56 + l));
    step();
    clear_in();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("postreset_rc", int'(bus.retire_count), 0);
      chk("postreset_empty", int'(bus.rob_empty), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
